reg_writeback: RTL and testbench

Register-file write-port owner for the 3-stage core. It merges single-cycle ALU results from execute with results from long-latency units (divider, load unit) into the single register-file write port. Completed long-latency results are held in a small in-order FIFO, and the block keeps a busy scoreboard of destinations with outstanding results so decode can stall. It sits between execute/multi-cycle units and the register file. It drives the register file's write address, data and enable.

---
 rtl/reg_writeback.sv | 118 +++++++++++
 tb/tb_reg_writeback.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Register-file write-port owner: merges zero-latency ALU results with buffered
// long-latency results and tracks destinations with outstanding results.
module reg_writeback #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          alu_wen,
    input  logic [4:0]                    alu_waddr,
    input  logic [31:0]                   alu_wdata,
    input  logic                          mc_issue,
    input  logic [4:0]                    mc_issue_rd,
    input  logic                          mc_valid,
    input  logic [4:0]                    mc_waddr,
    input  logic [31:0]                   mc_wdata,
    output logic                          mc_ready,
    output logic [4:0]                    reg_waddr,
    output logic [31:0]                   reg_wdata,
    output logic                          reg_wen,
    output logic [31:0]                   busy,
    output logic [$clog2(FIFO_DEPTH):0]   wb_pending
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [4:0]       addr_mem_r [FIFO_DEPTH];
    logic [31:0]      data_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      busy_r;

    logic             push_s;
    logic             pop_s;
    logic             empty_s;
    logic [4:0]       head_addr_s;
    logic [31:0]      head_data_s;
    logic [31:0]      clr_mask_s;
    logic [31:0]      set_mask_s;
    logic [31:0]      busy_next_s;

    assign empty_s     = (count_r == {CNT_W{1'b0}});
    assign mc_ready    = (count_r != FULL_CNT);
    assign push_s      = mc_valid && mc_ready;
    // The ALU always owns the port when it writes, so the head only drains on idle ALU cycles.
    assign pop_s       = !empty_s && !alu_wen;
    assign head_addr_s = addr_mem_r[rd_ptr_r];
    assign head_data_s = data_mem_r[rd_ptr_r];

    // Set beats clear on the same edge; x0 can never become busy.
    assign clr_mask_s  = pop_s ? (32'd1 << head_addr_s) : 32'd0;
    assign set_mask_s  = (mc_issue && (mc_issue_rd != 5'd0)) ? (32'd1 << mc_issue_rd) : 32'd0;
    assign busy_next_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~32'd1;

    assign busy        = busy_r;
    assign wb_pending  = count_r;

    // FIFO storage; contents are only observed while the occupancy says valid.
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            addr_mem_r[wr_ptr_r] <= mc_waddr;
            data_mem_r[wr_ptr_r] <= mc_wdata;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Outstanding-destination scoreboard.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Fixed-priority write-port mux, silenced while reset is asserted.
    always_comb begin
        reg_wen   = 1'b0;
        reg_waddr = 5'd0;
        reg_wdata = 32'd0;
        if (!sys_rst_n) begin
            reg_wen   = 1'b0;
        end else if (alu_wen) begin
            reg_wen   = 1'b1;
            reg_waddr = alu_waddr;
            reg_wdata = alu_wdata;
        end else if (!empty_s) begin
            reg_wen   = 1'b1;
            reg_waddr = head_addr_s;
            reg_wdata = head_data_s;
        end else begin
            reg_wen   = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: a queue-based reference model predicts each
// cycle's write and status; a negedge monitor pops and compares.
module tb_reg_writeback;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          alu_wen = 1'b0;
    logic [4:0]    alu_waddr = 5'd0;
    logic [31:0]   alu_wdata = 32'd0;
    logic          mc_issue = 1'b0;
    logic [4:0]    mc_issue_rd = 5'd0;
    logic          mc_valid = 1'b0;
    logic [4:0]    mc_waddr = 5'd0;
    logic [31:0]   mc_wdata = 32'd0;
    logic          mc_ready;
    logic [4:0]    reg_waddr;
    logic [31:0]   reg_wdata;
    logic          reg_wen;
    logic [31:0]   busy;
    logic [CW-1:0] wb_pending;

    reg_writeback #(.FIFO_DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .alu_wen(alu_wen), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
        .mc_valid(mc_valid), .mc_waddr(mc_waddr), .mc_wdata(mc_wdata),
        .mc_ready(mc_ready), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .reg_wen(reg_wen), .busy(busy), .wb_pending(wb_pending)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic rdy; int pend; logic [31:0] bsy; } st_t;

    int          checks = 0;
    int          failures = 0;
    wr_t         wr_q[$];
    st_t         st_q[$];
    logic [4:0]  mq_a[$];
    logic [31:0] mq_d[$];
    logic [4:0]  issued_q[$];
    logic [31:0] m_busy = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: one status entry per cycle, one write entry per observed write.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (st_q.size() > 0) begin
                st_t s;
                s = st_q.pop_front();
                chk("mc_ready", 64'(mc_ready), 64'(s.rdy));
                chk("wb_pending", 64'(wb_pending), 64'(s.pend));
                chk("busy", 64'(busy), 64'(s.bsy));
            end
            if (reg_wen) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 64'(reg_waddr), 64'hFFFF);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("reg_waddr", 64'(reg_waddr), 64'(w.a));
                    chk("reg_wdata", 64'(reg_wdata), 64'(w.d));
                end
            end else begin
                chk("idle_zero", {27'd0, reg_waddr, reg_wdata}, 64'd0);
            end
        end
    end

    // Predict this cycle from the model, then advance the model across the edge.
    task automatic step(output bit acc);
        st_t s;
        wr_t w;
        bit popped;
        logic [4:0] pa;
        logic [31:0] nb;
        s.rdy  = (mq_a.size() != DEPTH);
        s.pend = mq_a.size();
        s.bsy  = m_busy;
        st_q.push_back(s);
        popped = 1'b0;
        pa = 5'd0;
        if (alu_wen) begin
            w.a = alu_waddr; w.d = alu_wdata; wr_q.push_back(w);
        end else if (mq_a.size() > 0) begin
            popped = 1'b1;
            pa = mq_a.pop_front();
            w.a = pa; w.d = mq_d.pop_front(); wr_q.push_back(w);
        end
        acc = mc_valid && s.rdy;
        if (acc) begin
            mq_a.push_back(mc_waddr);
            mq_d.push_back(mc_wdata);
        end
        nb = m_busy;
        if (popped) nb[pa] = 1'b0;
        if (mc_issue && mc_issue_rd != 5'd0) nb[mc_issue_rd] = 1'b1;
        m_busy = nb;
        @(posedge sys_clk);
        #1;
        mc_issue = 1'b0;
    endtask

    task automatic step1();
        bit acc;
        step(acc);
    endtask

    task automatic issue(input logic [4:0] rd);
        mc_issue = 1'b1;
        mc_issue_rd = rd;
        step1();
    endtask

    task automatic mc_send(input logic [4:0] a, input logic [31:0] d);
        bit acc;
        acc = 1'b0;
        mc_valid = 1'b1; mc_waddr = a; mc_wdata = d;
        for (int i = 0; i < 20; i++) begin
            step(acc);
            if (acc) break;
        end
        mc_valid = 1'b0;
        if (!acc) chk("mc_accept_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [4:0] pick_free();
        logic [4:0] a;
        for (int t = 0; t < 40; t++) begin
            a = 5'($urandom_range(31, 0));
            if (!m_busy[a]) return a;
        end
        return 5'd0;
    endfunction

    initial begin
        bit acc;
        // Reset with active inputs: port silent, state empty.
        alu_wen = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'hAAAA_5555;
        mc_valid = 1'b1; mc_waddr = 5'd4; mc_wdata = 32'h1;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_reg_wen", 64'(reg_wen), 64'd0);
        chk("rst_reg_waddr", 64'(reg_waddr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mc_ready", 64'(mc_ready), 64'd1);
        chk("rst_wb_pending", 64'(wb_pending), 64'd0);
        mc_valid = 1'b0;
        sys_rst_n = 1'b1;

        // ALU passthrough including x0.
        alu_wen = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'h0000_1234; step1();
        alu_waddr = 5'd0; alu_wdata = 32'h0000_0055; step1();
        alu_wen = 1'b0; step1();

        // Basic multi-cycle path and issue to x0.
        issue(5'd5);
        mc_send(5'd5, 32'hDEAD_BEEF);
        step1(); step1();
        issue(5'd0);
        step1();

        // Contention: entry waits behind ALU writes.
        issue(5'd7);
        alu_wen = 1'b1; alu_waddr = 5'd1; alu_wdata = 32'h1111;
        mc_send(5'd7, 32'h77);
        alu_wdata = 32'h2222; step1();
        alu_wdata = 32'h3333; step1();
        alu_wdata = 32'h4444; step1();
        alu_wen = 1'b0; step1(); step1();

        // Fill to full, hold a third result, then drain in order.
        issue(5'd8); issue(5'd9); issue(5'd10);
        alu_wen = 1'b1; alu_waddr = 5'd2; alu_wdata = 32'h5A5A;
        mc_send(5'd8, 32'h8);
        mc_send(5'd9, 32'h9);
        mc_valid = 1'b1; mc_waddr = 5'd10; mc_wdata = 32'hA;
        step(acc); step(acc);
        alu_wen = 1'b0;
        mc_send(5'd10, 32'hA);
        repeat (4) step1();

        // Push and pop at count 1; set beats clear on x12.
        issue(5'd11); issue(5'd12);
        alu_wen = 1'b1; alu_waddr = 5'd1; alu_wdata = 32'hCAFE;
        mc_send(5'd11, 32'hB);
        alu_wen = 1'b0;
        mc_send(5'd12, 32'hC);
        issue(5'd12);
        step1(); step1();
        issued_q.push_back(5'd12);

        // Pointer wrap over six entries with mixed ALU traffic.
        for (int k = 0; k < 6; k++) issue(5'(14 + k));
        for (int k = 0; k < 6; k++) begin
            alu_wen = k[0]; alu_waddr = 5'd3; alu_wdata = 32'h900 + 32'(k);
            mc_send(5'(14 + k), 32'h100 + 32'(k));
        end
        alu_wen = 1'b0;
        repeat (4) step1();

        // Randomized traffic respecting the decode stall preconditions.
        for (int i = 0; i < 1500; i++) begin
            alu_wen = ($urandom_range(2, 0) == 0);
            alu_waddr = pick_free();
            alu_wdata = $urandom;
            if ($urandom_range(3, 0) == 0) begin
                mc_issue = 1'b1;
                mc_issue_rd = pick_free();
                issued_q.push_back(mc_issue_rd);
            end
            if (!mc_valid && issued_q.size() > 0 && $urandom_range(1, 0) == 1) begin
                mc_valid = 1'b1;
                mc_waddr = issued_q.pop_front();
                mc_wdata = $urandom;
            end
            step(acc);
            if (acc) mc_valid = 1'b0;
        end
        alu_wen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!mc_valid && issued_q.size() > 0) begin
                mc_valid = 1'b1; mc_waddr = issued_q.pop_front(); mc_wdata = $urandom;
            end
            step(acc);
            if (acc) mc_valid = 1'b0;
        end
        chk("drain_issued", 64'(issued_q.size()), 64'd0);

        // Reset mid-operation discards buffered results and busy bits at once.
        issue(5'd20); issue(5'd21);
        alu_wen = 1'b1; alu_waddr = 5'd1; alu_wdata = 32'hF00D;
        mc_send(5'd20, 32'h20);
        mc_send(5'd21, 32'h21);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_wb_pending", 64'(wb_pending), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_mc_ready", 64'(mc_ready), 64'd1);
        chk("midrst_reg_wen", 64'(reg_wen), 64'd0);
        wr_q.delete(); st_q.delete(); mq_a.delete(); mq_d.delete();
        m_busy = 32'd0;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        alu_wen = 1'b0; step1();
        alu_wen = 1'b1; alu_waddr = 5'd6; alu_wdata = 32'h600D; step1();
        alu_wen = 1'b0; step1(); step1();

        @(negedge sys_clk);
        #1;
        chk("scoreboard_drained", 64'(wr_q.size()), 64'd0);
        chk("final_busy", 64'(busy), 64'(m_busy));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
